pipeline_ctrl: RTL

//  Consumer side of the hazard unit's freeze/flush pair. Combines freeze/flush with cache handshakes
//  (ihit, dhit) and the HALT in MEM/WB; drives per-latch enables/flushes and PC enable for the 5-stage pipe.

---
 rtl/pipeline_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
//============================================================================
// pipeline_ctrl : pipeline latch/PC enable and flush control for a 5-stage
//                 pipe, with stall/bubble/flush performance counters.
// Revision 1.0
//============================================================================
`default_nettype none

module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             freeze,
    input  logic             flush,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    logic             r_mem_done;
    logic             r_flush_pend;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_run;
    logic w_mem_ok;
    logic w_advance;
    logic w_do_stall;
    logic w_do_flush;
    logic w_do_bubble;

    // A data access counts as finished if it completes now or completed
    // earlier while the pipe was still waiting on the icache.
    assign w_run       = nRST && (r_state == ST_RUN);
    assign w_mem_ok    = ~dmem_req | dhit | r_mem_done;
    assign w_advance   = ihit & w_mem_ok;
    assign w_do_stall  = w_run & ~w_advance;
    assign w_do_flush  = w_run & w_advance & (flush | r_flush_pend);
    assign w_do_bubble = w_run & w_advance & ~(flush | r_flush_pend) & freeze;

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        if (w_do_flush) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
        end else if (w_do_bubble) begin
            // Hold PC and IF/ID, push a bubble into ID/EX.
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
        end else if (w_run && w_advance) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
        end
    end

    assign halted     = nRST && (r_state == ST_HALT);
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state      <= ST_RUN;
            r_mem_done   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_advance) begin
                        r_mem_done   <= 1'b0;
                        r_flush_pend <= 1'b0;
                    end else begin
                        if (dhit)  r_mem_done   <= 1'b1;
                        if (flush) r_flush_pend <= 1'b1;
                    end

                    if (w_do_stall && (r_stall_cnt != c_CNT_MAX))
                        r_stall_cnt <= r_stall_cnt + 1'b1;
                    if (w_do_bubble && (r_bubble_cnt != c_CNT_MAX))
                        r_bubble_cnt <= r_bubble_cnt + 1'b1;
                    if (w_do_flush && (r_flush_cnt != c_CNT_MAX))
                        r_flush_cnt <= r_flush_cnt + 1'b1;

                    if (halt_wb) r_state <= ST_HALT;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
